// File: rtl/cp0_regfile.sv
// CP0 system-control register file.
// Decodes mtc0/mfc0 accesses, forwards MMU-owned registers to the MMU, and holds
// Count/Compare, Status, Cause and EPC with exception entry, ERET and interrupt request.
module cp0_regfile #(
    parameter int unsigned HW_IRQS   = 6,
    parameter int unsigned COUNT_DIV = 2,
    parameter logic [31:0] MMU_MASK  = 32'h0000047F
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               we,
    input  logic               re,
    input  logic [4:0]         rd,
    input  logic [2:0]         sel,
    input  logic [31:0]        dataIn,
    output logic [31:0]        dataOut,
    input  logic [31:0]        mmu_dataOut,
    output logic [31:0]        mmu_dataIn,
    output logic [4:0]         mmu_rd,
    output logic               readMMUReg,
    output logic               writeMMUReg,
    input  logic [HW_IRQS-1:0] hw_irq,
    input  logic               exc_valid,
    input  logic [4:0]         exc_code,
    input  logic [31:0]        exc_pc,
    input  logic               exc_bd,
    input  logic               eret,
    output logic [31:0]        epc_out,
    output logic               exl,
    output logic               irq_req
);

    localparam logic [4:0]  REG_COUNT   = 5'd9;
    localparam logic [4:0]  REG_COMPARE = 5'd11;
    localparam logic [4:0]  REG_STATUS  = 5'd12;
    localparam logic [4:0]  REG_CAUSE   = 5'd13;
    localparam logic [4:0]  REG_EPC     = 5'd14;
    localparam logic [31:0] PRESC_LAST  = 32'(COUNT_DIV - 1);

    logic        is_mmu;
    logic        local_we;
    logic        rd_take;
    logic        wr_count, wr_compare, wr_status, wr_cause, wr_epc;
    logic        count_tick;

    logic [31:0] count_q;
    logic [31:0] presc_q;
    logic [31:0] compare_q;
    logic [7:0]  im_q;
    logic        exl_q;
    logic        ie_q;
    logic        bd_q;
    logic        ti_q;
    logic [1:0]  ipsw_q;
    logic [5:0]  iphw_q;
    logic [4:0]  exccode_q;
    logic [31:0] epc_q;
    logic [31:0] rdata_q;
    logic        rd_mmu_q;
    logic        irq_req_q;

    logic [5:0]  hw_pad;
    logic [7:0]  cause_ip;
    logic [31:0] status_val;
    logic [31:0] cause_val;
    logic [31:0] local_rdata;

    assign is_mmu      = MMU_MASK[rd];
    assign local_we    = we & ~is_mmu & (sel == 3'd0);
    assign rd_take     = re & ~we;
    assign wr_count    = local_we & (rd == REG_COUNT);
    assign wr_compare  = local_we & (rd == REG_COMPARE);
    assign wr_status   = local_we & (rd == REG_STATUS);
    assign wr_cause    = local_we & (rd == REG_CAUSE);
    assign wr_epc      = local_we & (rd == REG_EPC);
    assign count_tick  = ~wr_count & (presc_q == PRESC_LAST);

    assign mmu_dataIn  = dataIn;
    assign mmu_rd      = rd;
    assign readMMUReg  = re & is_mmu;
    assign writeMMUReg = we & is_mmu;
    assign dataOut     = rd_mmu_q ? mmu_dataOut : rdata_q;
    assign epc_out     = epc_q;
    assign exl         = exl_q;
    assign irq_req     = irq_req_q;

    // Widen the hardware lines to the six IP slots; unused slots read as zero.
    always_comb begin
        hw_pad                = '0;
        hw_pad[HW_IRQS-1:0]   = hw_irq;
    end

    // Assemble architectural Status/Cause views; IP[7] shares the timer with line 5.
    always_comb begin
        cause_ip    = {iphw_q, ipsw_q};
        cause_ip[7] = iphw_q[5] | ti_q;
        status_val  = {16'h0000, im_q, 6'b000000, exl_q, ie_q};
        cause_val   = {bd_q, ti_q, 14'h0000, cause_ip, 1'b0, exccode_q, 2'b00};
    end

    // Local read multiplexer; unimplemented (rd,sel) pairs read zero.
    always_comb begin
        local_rdata = '0;
        if (sel == 3'd0) begin
            case (rd)
                REG_COUNT:   local_rdata = count_q;
                REG_COMPARE: local_rdata = compare_q;
                REG_STATUS:  local_rdata = status_val;
                REG_CAUSE:   local_rdata = cause_val;
                REG_EPC:     local_rdata = epc_q;
                default:     local_rdata = '0;
            endcase
        end
    end

    // Count and its prescaler; a Count write restarts the prescaler.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            presc_q <= '0;
        end else if (wr_count) begin
            count_q <= dataIn;
            presc_q <= '0;
        end else if (presc_q == PRESC_LAST) begin
            count_q <= count_q + 32'd1;
            presc_q <= '0;
        end else begin
            presc_q <= presc_q + 32'd1;
        end
    end

    // Compare register and timer interrupt flag; a Compare write clears TI over a match.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            compare_q <= '0;
            ti_q      <= 1'b0;
        end else if (wr_compare) begin
            compare_q <= dataIn;
            ti_q      <= 1'b0;
        end else if (count_tick && ((count_q + 32'd1) == compare_q)) begin
            ti_q      <= 1'b1;
        end
    end

    // Status; exception entry and ERET override the written EXL bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            im_q  <= '0;
            ie_q  <= 1'b0;
            exl_q <= 1'b1;
        end else begin
            if (wr_status) begin
                im_q <= dataIn[15:8];
                ie_q <= dataIn[0];
            end
            if (exc_valid)
                exl_q <= 1'b1;
            else if (eret)
                exl_q <= 1'b0;
            else if (wr_status)
                exl_q <= dataIn[1];
        end
    end

    // Cause fields and EPC; exception capture wins over a same-cycle EPC write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ipsw_q    <= '0;
            iphw_q    <= '0;
            bd_q      <= 1'b0;
            exccode_q <= '0;
            epc_q     <= '0;
        end else begin
            iphw_q <= hw_pad;
            if (wr_cause)
                ipsw_q <= dataIn[9:8];
            if (exc_valid)
                exccode_q <= exc_code;
            if (exc_valid && !exl_q) begin
                bd_q  <= exc_bd;
                epc_q <= exc_bd ? (exc_pc - 32'd4) : exc_pc;
            end else if (wr_epc) begin
                epc_q <= dataIn;
            end
        end
    end

    // mfc0 capture: remember the source and snapshot the local value before this edge's updates.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q  <= '0;
            rd_mmu_q <= 1'b0;
        end else if (rd_take) begin
            rdata_q  <= local_rdata;
            rd_mmu_q <= is_mmu;
        end
    end

    // Registered interrupt request from the current Status/Cause state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            irq_req_q <= 1'b0;
        else
            irq_req_q <= ie_q & ~exl_q & (|(cause_ip & im_q));
    end

endmodule
